// File: rtl/tb_tcdm_mem_model_if.sv
// rtl/tb_tcdm_mem_model_if.sv - TCDM port bundle between accelerator masters and the memory model
interface tb_tcdm_mem_model_if #(
  parameter int MP = 4,
  parameter int DW = 32
);
  logic [MP-1:0]                req;
  logic [MP-1:0]                gnt;
  logic [MP-1:0][31:0]          add;
  logic [MP-1:0]                wen;
  logic [MP-1:0][DW/8-1:0]      be;
  logic [MP-1:0][DW-1:0]        data;
  logic [MP-1:0][DW-1:0]        r_data;
  logic [MP-1:0]                r_valid;

  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data,
    output gnt, r_data, r_valid
  );
endinterface

// File: rtl/tb_tcdm_mem_model.sv
// rtl/tb_tcdm_mem_model.sv - banked TCDM memory model with RR arbitration, stall injection and init fill
module tb_tcdm_mem_model #(
  parameter int          MP          = 4,
  parameter int          DW          = 32,
  parameter int          MEMORY_SIZE = 1024,
  parameter int          NB_BANKS    = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          LATENCY     = 1,
  parameter int          STALL_TH    = 0,
  parameter logic [15:0] SEED        = 16'h1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                stallable_i,
  input  logic                init_i,
  input  logic                clear_i,
  output logic                busy_o,
  output logic                err_o,
  tb_tcdm_mem_model_if.slave  tcdm,
  output logic [MP-1:0][31:0] cnt_gnt_o,
  output logic [MP-1:0][31:0] cnt_stall_o
);
  localparam int NBYTES = DW / 8;
  localparam int OFFW   = $clog2(NBYTES);
  localparam int NL     = DW / 32;
  localparam int AW     = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam int PW     = (MP > 1) ? $clog2(MP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_INIT} state_e;

  state_e                             state_q, state_d;
  logic [AW-1:0]                      init_cnt_q, init_cnt_d;
  logic                               init_we;
  logic [MP-1:0][15:0]                lfsr_q, lfsr_d;
  logic [NB_BANKS-1:0][PW-1:0]        rr_q, rr_d;
  logic [LATENCY-1:0][MP-1:0]         vld_q, vld_d;
  logic [LATENCY-1:0][MP-1:0][DW-1:0] dat_q, dat_d;
  logic [MP-1:0][31:0]                cnt_gnt_q, cnt_gnt_d;
  logic [MP-1:0][31:0]                cnt_stall_q, cnt_stall_d;
  logic                               err_q, err_d;

  // Storage is deliberately not reset: contents survive reset and aborted fills.
  logic [DW-1:0] mem_q [MEMORY_SIZE];

  logic [MP-1:0][31:0]   off, word_idx, bank_idx;
  logic [MP-1:0][AW-1:0] mem_idx;
  logic [MP-1:0]         bad, stalled, elig, gnt, wr_en;
  logic [MP-1:0][DW-1:0] rsp_data;
  logic [NB_BANKS-1:0]   bank_taken;

  // Address decode, stall decision and eligibility per port
  always_comb begin
    for (int p = 0; p < MP; p++) begin
      off[p]      = tcdm.add[p] - BASE_ADDR;
      word_idx[p] = off[p] >> OFFW;
      bank_idx[p] = word_idx[p] & 32'(NB_BANKS - 1);
      mem_idx[p]  = word_idx[p][AW-1:0];
      bad[p]      = (tcdm.add[p] < BASE_ADDR) ||
                    (word_idx[p] >= 32'(MEMORY_SIZE)) ||
                    ((tcdm.add[p] & 32'(NBYTES - 1)) != 32'd0);
      stalled[p]  = stallable_i && ({22'd0, lfsr_q[p][9:0]} < 32'(STALL_TH));
      elig[p]     = tcdm.req[p] && enable_i && (state_q == S_RUN) && !stalled[p];
    end
  end

  // Per-bank round-robin: scan ports from the bank pointer, first eligible hit wins
  always_comb begin : arb
    int p;
    p          = 0;
    gnt        = '0;
    rr_d       = rr_q;
    bank_taken = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      for (int k = 0; k < MP; k++) begin
        p = (int'(rr_q[b]) + k) % MP;
        if (!bank_taken[b] && elig[p] && (bank_idx[p] == 32'(b))) begin
          gnt[p]        = 1'b1;
          bank_taken[b] = 1'b1;
          rr_d[b]       = PW'((p + 1) % MP);
        end
      end
    end
  end

  // Response word: error pattern, plain read, or the post-write merged word
  always_comb begin
    for (int p = 0; p < MP; p++) begin
      rsp_data[p] = '0;
      wr_en[p]    = gnt[p] && !tcdm.wen[p] && !bad[p];
      if (bad[p]) begin
        rsp_data[p] = {NL{32'hDEADBEEF}};
      end else begin
        rsp_data[p] = mem_q[mem_idx[p]];
        if (!tcdm.wen[p]) begin
          for (int i = 0; i < NBYTES; i++) begin
            if (tcdm.be[p][i]) rsp_data[p][i*8 +: 8] = tcdm.data[p][i*8 +: 8];
          end
        end
      end
    end
  end

  // Control FSM: one idle cycle after reset, then RUN; INIT fills one word per cycle
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_we    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        if (init_i) begin
          state_d    = S_INIT;
          init_cnt_d = '0;
        end
      end
      S_INIT: begin
        init_we    = 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == AW'(MEMORY_SIZE - 1)) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response pipeline, LFSRs, counters and sticky error
  always_comb begin
    vld_d[0] = gnt;
    for (int p = 0; p < MP; p++) begin
      dat_d[0][p]    = gnt[p] ? rsp_data[p] : '0;
      lfsr_d[p]      = lfsr_q[p][0] ? ((lfsr_q[p] >> 1) ^ 16'hB400) : (lfsr_q[p] >> 1);
      cnt_gnt_d[p]   = clear_i ? 32'd0 : cnt_gnt_q[p] + 32'(gnt[p]);
      cnt_stall_d[p] = clear_i ? 32'd0 : cnt_stall_q[p] + 32'(tcdm.req[p] && !gnt[p]);
    end
    for (int s = 1; s < LATENCY; s++) begin
      vld_d[s] = vld_q[s-1];
      dat_d[s] = dat_q[s-1];
    end
    err_d = (clear_i ? 1'b0 : err_q) | (|(gnt & bad));
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      init_cnt_q  <= '0;
      rr_q        <= '0;
      vld_q       <= '0;
      dat_q       <= '0;
      cnt_gnt_q   <= '0;
      cnt_stall_q <= '0;
      err_q       <= 1'b0;
      for (int p = 0; p < MP; p++) lfsr_q[p] <= SEED + 16'(p);
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_q        <= rr_d;
      vld_q       <= vld_d;
      dat_q       <= dat_d;
      cnt_gnt_q   <= cnt_gnt_d;
      cnt_stall_q <= cnt_stall_d;
      err_q       <= err_d;
      lfsr_q      <= lfsr_d;
    end
  end

  // Memory writes: pattern fill or granted port writes (never both in one cycle)
  always_ff @(posedge clk_i) begin
    if (init_we) mem_q[init_cnt_q] <= {NL{32'(init_cnt_q)}};
    for (int p = 0; p < MP; p++) begin
      if (wr_en[p]) mem_q[mem_idx[p]] <= rsp_data[p];
    end
  end

  assign tcdm.gnt     = gnt;
  assign tcdm.r_valid = vld_q[LATENCY-1];
  assign tcdm.r_data  = dat_q[LATENCY-1];
  assign busy_o       = (state_q == S_INIT);
  assign err_o        = err_q;
  assign cnt_gnt_o    = cnt_gnt_q;
  assign cnt_stall_o  = cnt_stall_q;
endmodule

// File: tb/tb_tb_tcdm_mem_model.sv
// tb/tb_tb_tcdm_mem_model.sv - directed bench for the TCDM memory model
module tb_tb_tcdm_mem_model;
  localparam int MP = 4;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic stallable = 1'b0;
  logic init = 1'b0;
  logic clear = 1'b0;
  logic busy, err;
  logic [MP-1:0][31:0] cnt_gnt, cnt_stall;

  int n_pass = 0;
  int n_total = 0;
  bit trace1 [10000];
  bit trace2 [10000];

  tb_tcdm_mem_model_if #(.MP(MP), .DW(DW)) bus ();

  tb_tcdm_mem_model #(
    .MP(MP), .DW(DW), .MEMORY_SIZE(1024), .NB_BANKS(4), .BASE_ADDR(32'h0),
    .LATENCY(2), .STALL_TH(512), .SEED(16'h1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .stallable_i(stallable),
    .init_i(init), .clear_i(clear), .busy_o(busy), .err_o(err),
    .tcdm(bus), .cnt_gnt_o(cnt_gnt), .cnt_stall_o(cnt_stall)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input int p, input logic [31:0] a, input logic w, input logic [7:0] b,
                        input logic [63:0] d, output logic g, output logic v, output logic [63:0] rd);
    bus.req[p] = 1'b1; bus.add[p] = a; bus.wen[p] = w; bus.be[p] = b; bus.data[p] = d;
    @(negedge clk);
    g = bus.gnt[p];
    next_cycle();
    bus.req[p] = 1'b0;
    next_cycle();
    @(negedge clk);
    v = bus.r_valid[p];
    rd = bus.r_data[p];
    next_cycle();
  endtask

  task automatic test_reset();
    bus.req = '0; bus.add = '0; bus.wen = '1; bus.be = '0; bus.data = '0;
    repeat (3) @(posedge clk);
    #1;
    bus.req = 4'hF;
    @(negedge clk);
    n_total++; if (bus.gnt !== 4'h0) $display("FAIL reset_gnt: got %h want 0", bus.gnt); else n_pass++;
    n_total++; if (bus.r_valid !== 4'h0) $display("FAIL reset_r_valid: got %h want 0", bus.r_valid); else n_pass++;
    n_total++; if (bus.r_data !== '0) $display("FAIL reset_r_data: got %h want 0", bus.r_data); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    n_total++; if (cnt_gnt !== '0 || cnt_stall !== '0)
      $display("FAIL reset_counters: got %h/%h want 0", cnt_gnt, cnt_stall); else n_pass++;
    next_cycle();
    bus.req = '0;
    rst_n = 1'b1;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_init();
    int cnt;
    bit saw_gnt;
    cnt = 0;
    saw_gnt = 0;
    init = 1'b1;
    next_cycle();
    init = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else if (cnt > 0) break;
      if (bus.gnt !== 4'h0) saw_gnt = 1;
      next_cycle();
      init = (cnt == 500);
      bus.req[3] = (cnt >= 500 && cnt < 510);
    end
    bus.req = '0;
    n_total++; if (cnt !== 1024) $display("FAIL init_busy_cycles: got %0d want 1024", cnt); else n_pass++;
    n_total++; if (saw_gnt) $display("FAIL init_no_gnt: got grant during init want none"); else n_pass++;
    n_total++; if (cnt_stall[3] !== 32'd10) $display("FAIL init_stall_cnt: got %0d want 10", cnt_stall[3]); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL init_busy_low: got %b want 0", busy); else n_pass++;
    next_cycle();
  endtask

  task automatic test_read();
    bus.req[0] = 1'b1; bus.add[0] = 32'h10; bus.wen[0] = 1'b1;
    @(negedge clk);
    n_total++; if (bus.gnt !== 4'b0001) $display("FAIL read_gnt: got %b want 0001", bus.gnt); else n_pass++;
    next_cycle();
    bus.req[0] = 1'b0;
    @(negedge clk);
    n_total++; if (bus.r_valid[0] !== 1'b0) $display("FAIL read_early_valid: got %b want 0", bus.r_valid[0]); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.r_valid[0] !== 1'b1) $display("FAIL read_valid: got %b want 1", bus.r_valid[0]); else n_pass++;
    n_total++; if (bus.r_data[0] !== 64'h00000002_00000002)
      $display("FAIL read_data: got %h want 0000000200000002", bus.r_data[0]); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.r_valid[0] !== 1'b0 || bus.r_data[0] !== 64'h0)
      $display("FAIL read_idle_zero: got %b/%h want 0/0", bus.r_valid[0], bus.r_data[0]); else n_pass++;
    next_cycle();
  endtask

  task automatic test_write_be();
    bus.req[2] = 1'b1; bus.add[2] = 32'h28; bus.wen[2] = 1'b0;
    bus.be[2] = 8'h0F; bus.data[2] = 64'hFFFFFFFF_12345678;
    @(negedge clk);
    n_total++; if (bus.gnt[2] !== 1'b1) $display("FAIL wr_gnt: got %b want 1", bus.gnt[2]); else n_pass++;
    next_cycle();
    bus.wen[2] = 1'b1;
    @(negedge clk);
    n_total++; if (bus.gnt[2] !== 1'b1) $display("FAIL raw_gnt: got %b want 1", bus.gnt[2]); else n_pass++;
    next_cycle();
    bus.req[2] = 1'b0;
    @(negedge clk);
    n_total++; if (bus.r_valid[2] !== 1'b1 || bus.r_data[2] !== 64'h00000005_12345678)
      $display("FAIL wr_rsp: got %b/%h want 1/0000000512345678", bus.r_valid[2], bus.r_data[2]); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.r_valid[2] !== 1'b1 || bus.r_data[2] !== 64'h00000005_12345678)
      $display("FAIL raw_rsp: got %b/%h want 1/0000000512345678", bus.r_valid[2], bus.r_data[2]); else n_pass++;
    next_cycle();
  endtask

  task automatic test_conflict();
    logic [1:0] exp_g;
    bus.req[0] = 1'b1; bus.add[0] = 32'h0;  bus.wen[0] = 1'b1;
    bus.req[1] = 1'b1; bus.add[1] = 32'h20; bus.wen[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      n_total++; if (bus.gnt[1:0] !== exp_g)
        $display("FAIL conflict_gnt_%0d: got %b want %b", i, bus.gnt[1:0], exp_g); else n_pass++;
      next_cycle();
    end
    bus.req = '0;
    @(negedge clk);
    n_total++; if (cnt_stall[0] !== 32'd4 || cnt_stall[1] !== 32'd4)
      $display("FAIL conflict_stall_cnt: got %0d/%0d want 4/4", cnt_stall[0], cnt_stall[1]); else n_pass++;
    n_total++; if (cnt_gnt[0] !== 32'd5 || cnt_gnt[1] !== 32'd4)
      $display("FAIL conflict_gnt_cnt: got %0d/%0d want 5/4", cnt_gnt[0], cnt_gnt[1]); else n_pass++;
    next_cycle();
  endtask

  task automatic test_enable();
    bus.req[3] = 1'b1; bus.add[3] = 32'h18; bus.wen[3] = 1'b1;
    @(negedge clk);
    n_total++; if (bus.gnt !== 4'b1000) $display("FAIL en_first_gnt: got %b want 1000", bus.gnt); else n_pass++;
    next_cycle();
    enable = 1'b0;
    @(negedge clk);
    n_total++; if (bus.gnt !== 4'h0) $display("FAIL en_low_gnt: got %b want 0000", bus.gnt); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.r_valid[3] !== 1'b1 || bus.r_data[3] !== 64'h00000003_00000003)
      $display("FAIL en_inflight: got %b/%h want 1/0000000300000003", bus.r_valid[3], bus.r_data[3]); else n_pass++;
    next_cycle();
    bus.req = '0;
    enable = 1'b1;
    @(negedge clk);
    n_total++; if (cnt_stall[3] !== 32'd12) $display("FAIL en_stall_cnt: got %0d want 12", cnt_stall[3]); else n_pass++;
    next_cycle();
  endtask

  task automatic test_bad();
    logic g, v;
    logic [63:0] rd;
    access(1, 32'h2000, 1'b1, 8'h00, 64'h0, g, v, rd);
    n_total++; if (g !== 1'b1) $display("FAIL bad_gnt: got %b want 1", g); else n_pass++;
    n_total++; if (v !== 1'b1 || rd !== 64'hDEADBEEF_DEADBEEF)
      $display("FAIL bad_rsp: got %b/%h want 1/deadbeefdeadbeef", v, rd); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL bad_err: got %b want 1", err); else n_pass++;
    access(2, 32'h2C, 1'b0, 8'hFF, 64'h0, g, v, rd);
    n_total++; if (rd !== 64'hDEADBEEF_DEADBEEF) $display("FAIL misalign_rsp: got %h want deadbeefdeadbeef", rd); else n_pass++;
    access(2, 32'h28, 1'b1, 8'h00, 64'h0, g, v, rd);
    n_total++; if (rd !== 64'h00000005_12345678) $display("FAIL misalign_untouched: got %h want 0000000512345678", rd); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else n_pass++;
    n_total++; if (cnt_gnt[1] !== 32'd5) $display("FAIL bad_gnt_cnt: got %0d want 5", cnt_gnt[1]); else n_pass++;
    clear = 1'b1;
    bus.req[1] = 1'b1; bus.add[1] = 32'h2000; bus.wen[1] = 1'b1;
    @(negedge clk);
    next_cycle();
    clear = 1'b0;
    bus.req = '0;
    @(negedge clk);
    n_total++; if (err !== 1'b1) $display("FAIL clear_vs_err: got %b want 1", err); else n_pass++;
    n_total++; if (cnt_gnt[1] !== 32'd0 || cnt_stall[3] !== 32'd0)
      $display("FAIL clear_counters: got %0d/%0d want 0/0", cnt_gnt[1], cnt_stall[3]); else n_pass++;
    next_cycle();
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    @(negedge clk);
    n_total++; if (err !== 1'b0) $display("FAIL clear_err: got %b want 0", err); else n_pass++;
    next_cycle();
  endtask

  task automatic test_reset_mid_init();
    logic g, v;
    logic [63:0] rd;
    int cnt;
    access(0, 32'h1F40, 1'b0, 8'hFF, 64'hA5A50000_11112222, g, v, rd);
    access(1, 32'h2000, 1'b1, 8'h00, 64'h0, g, v, rd);
    n_total++; if (err !== 1'b1 || cnt_gnt[1] !== 32'd1)
      $display("FAIL pre_reset_state: got %b/%0d want 1/1", err, cnt_gnt[1]); else n_pass++;
    init = 1'b1;
    next_cycle();
    init = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      if (cnt == 100) break;
      next_cycle();
    end
    n_total++; if (cnt !== 100) $display("FAIL midinit_reached: got %0d want 100", cnt); else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL midinit_rst_flags: got %b/%b want 0/0", busy, err); else n_pass++;
    n_total++; if (cnt_gnt !== '0 || bus.r_valid !== 4'h0 || bus.r_data !== '0)
      $display("FAIL midinit_rst_outs: got %h/%b want 0/0", cnt_gnt, bus.r_valid); else n_pass++;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL midinit_busy_after: got %b want 0", busy); else n_pass++;
    next_cycle();
    access(0, 32'h190, 1'b1, 8'h00, 64'h0, g, v, rd);
    n_total++; if (rd !== 64'h00000032_00000032) $display("FAIL midinit_word50: got %h want 0000003200000032", rd); else n_pass++;
    access(0, 32'h1F40, 1'b1, 8'h00, 64'h0, g, v, rd);
    n_total++; if (rd !== 64'hA5A50000_11112222) $display("FAIL midinit_word1000: got %h want a5a5000011112222", rd); else n_pass++;
  endtask

  task automatic stall_run(input bit second, output int stalls);
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    repeat (3) next_cycle();
    bus.req[0] = 1'b1; bus.add[0] = 32'h0; bus.wen[0] = 1'b1;
    stalls = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (second) trace2[i] = bus.gnt[0];
      else trace1[i] = bus.gnt[0];
      if (!bus.gnt[0]) stalls++;
      next_cycle();
    end
    bus.req[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stall_inject();
    int stalls1, stalls2, diffs;
    bus.req[0] = 1'b1; bus.add[0] = 32'h0; bus.wen[0] = 1'b1;
    @(negedge clk);
    n_total++; if (bus.gnt[0] !== 1'b1) $display("FAIL drop_gnt: got %b want 1", bus.gnt[0]); else n_pass++;
    next_cycle();
    bus.req[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.r_valid[0] !== 1'b0) $display("FAIL inflight_dropped: got %b want 0", bus.r_valid[0]); else n_pass++;
    next_cycle();
    stallable = 1'b1;
    stall_run(1'b0, stalls1);
    n_total++; if (stalls1 < 4700 || stalls1 > 5300)
      $display("FAIL stall_ratio: got %0d/10000 want 4700..5300", stalls1); else n_pass++;
    n_total++; if (cnt_stall[0] !== 32'(stalls1) || cnt_gnt[0] !== 32'(10000 - stalls1))
      $display("FAIL stall_counters: got %0d/%0d want %0d/%0d", cnt_stall[0], cnt_gnt[0], stalls1, 10000 - stalls1); else n_pass++;
    next_cycle();
    stall_run(1'b1, stalls2);
    diffs = 0;
    for (int i = 0; i < 10000; i++) if (trace1[i] != trace2[i]) diffs++;
    n_total++; if (diffs != 0 || stalls2 != stalls1)
      $display("FAIL stall_repeat: got %0d differing cycles (%0d vs %0d stalls) want 0", diffs, stalls2, stalls1); else n_pass++;
    stallable = 1'b0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_init();
    test_read();
    test_write_be();
    test_conflict();
    test_enable();
    test_bad();
    test_reset_mid_init();
    test_stall_inject();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tb_tcdm_mem_model.md
# tb_tcdm_mem_model

Parametrised multi-port TCDM memory model for block-level accelerator benches. It replaces the fixed 32-bit, single-latency dummy memory. The model adds:
- configurable data width, depth, bank count and read latency;
- per-bank round-robin arbitration with real bank conflicts;
- reproducible LFSR-driven stall injection;
- an init state machine that fills memory with a known pattern;
- out-of-range error flagging and per-port statistics counters.

It sits between the accelerator's TCDM master ports and the bench.

## Interface
- MP, 4, number of TCDM ports
- DW, 32, data width in bits (multiple of 32)
- MEMORY_SIZE, 1024, depth in DW-bit words
- NB_BANKS, 4, word-interleaved banks (power of two, ≥1)
- BASE_ADDR, 0, byte address of word 0
- LATENCY, 1, grant-to-r_valid cycles (1..4)
- STALL_TH, 0, stall threshold out of 1024 (0 = never, 1024 = always)
- SEED, 16'h1, LFSR seed base (port i uses SEED+i; must stay nonzero)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  when low, no grants are issued
- stallable_i  in  1  enables LFSR stall injection
- init_i  in  1  one-cycle pulse: start pattern fill
- clear_i  in  1  synchronous clear of counters and err_o
- busy_o  out  1  init in progress
- err_o  out  1  sticky out-of-range or misaligned access
- tcdm_req_i  in  MP  request
- tcdm_gnt_o  out  MP  grant, combinational from req
- tcdm_add_i  in  MP×32  byte address
- tcdm_wen_i  in  MP  1 = read, 0 = write
- tcdm_be_i  in  MP×DW/8  byte enables
- tcdm_data_i  in  MP×DW  write data
- tcdm_r_data_o  out  MP×DW  response data
- tcdm_r_valid_o  out  MP  response valid
- cnt_gnt_o  out  MP×32  granted transactions
- cnt_stall_o  out  MP×32  cycles with req high and gnt low

## Operation
- **States.** IDLE after reset goes to RUN. RUN + init_i goes to INIT. INIT runs MEMORY_SIZE cycles, then returns to RUN.
- **INIT.** Writes word k = k replicated in every 32-bit lane, one word per cycle, k = 0..MEMORY_SIZE-1.
  - busy_o = 1 and all gnt = 0 during INIT.
  - init_i is ignored while in INIT.
- **Word index and bank.** w = (add − BASE_ADDR) >> log2(DW/8); bank = w mod NB_BANKS.
- **Stall.** Each port has a 16-bit Galois LFSR (mask 16'hB400) that advances every cycle.
  - Port i is stalled when stallable_i && lfsr_i[9:0] < STALL_TH.
- **Arbitration.** A port is eligible when req && enable_i && state == RUN && !stalled.
  - Each bank grants at most one eligible port per cycle, round-robin.
  - The bank's pointer moves to (granted port + 1) mod MP only on a grant.
- **Read.** A granted read returns mem[w].
- **Write.** A granted write updates the enabled bytes.
  - The response returns the full post-write word with r_valid = 1.
- **Bad access.** Out-of-range (w ≥ MEMORY_SIZE or add < BASE_ADDR) or misaligned (low address bits nonzero):
  - the access is granted, memory is untouched;
  - r_data = 32'hDEADBEEF in every lane;
  - err_o is set.
- **Clearing.** clear_i zeroes the counters and err_o. If clear_i coincides with a new error, err_o ends at 1.
- **Counters.** Counters wrap at 2^32.
- **Memory contents.** Memory is not reset; contents before the first INIT or write are X.

## Timing
- **Reset values.** gnt 0, r_valid 0, r_data 0, busy_o 0, err_o 0, counters 0, RR pointers 0, lfsr_i = SEED+i.
- **Grant.** gnt is combinational in the request cycle t.
- **Response.** r_valid/r_data appear at cycle t+LATENCY through a LATENCY-stage per-port pipeline. Back-to-back grants give back-to-back responses.
- **Read-after-write.** A write granted at t is visible to any read granted at t+1 or later. A same-cycle read and write to one word cannot occur (same bank).
- **Reset mid-operation.**
  - Responses still in flight are dropped.
  - An INIT in progress is aborted; words not yet written keep their old value.
- **enable_i low.**
  - No new grants.
  - Responses already in flight still complete.
  - The stall counter increments for requesting ports.
- **Disabled ports.** r_data is 0 whenever r_valid is 0.

## Test plan
- **Init and read.** MP=4, DW=64, LATENCY=2, init_i pulse → busy_o high for exactly 1024 cycles. Then a port 0 read of add 0x10 (w=2) gives r_valid at t+2 with r_data = 64'h00000002_00000002.
- **Bank conflict.** Ports 0 and 1 both read w=0 and w=4 (bank 0, NB_BANKS=4) continuously → grants alternate 0,1,0,1. cnt_stall_o[0] and cnt_stall_o[1] each increase by 1 every 2 cycles.
- **Byte-enabled write.** Port 2 writes be=8'h0F, data 64'hFFFF_FFFF_1234_5678 to w=5 after init → the write response is 64'h00000005_12345678. A read at the next cycle returns the same value.
- **Stall injection.** STALL_TH=512, stallable_i=1, 10000 cycles of continuous requests on one port → stall ratio is 0.5±0.03. Two runs with the same SEED produce identical gnt traces.
- **Bad access.** A read of BASE_ADDR + MEMORY_SIZE*DW/8 → granted, r_data = all-DEADBEEF, err_o=1 and sticky. clear_i → err_o=0.
- **Reset mid-INIT.** rst_ni low at cycle 100 of INIT → all outputs are at reset values the same cycle. After release, busy_o=0, and word 50 still reads 50.
